regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 39 +++
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle for regfile_scoreboard: operand reads,
// writeback port, issue request and the scoreboard status it returns.
interface regfile_scoreboard_if #(
  parameter int XLEN      = 32,
  parameter int REG_BITS  = 5,
  parameter int MUL_DEPTH = 5
);
  localparam int CNT_BITS = $clog2(MUL_DEPTH + 1);

  logic                flush_in;
  logic [REG_BITS-1:0] rs1_in;
  logic [REG_BITS-1:0] rs2_in;
  logic [XLEN-1:0]     rs1_data_out;
  logic [XLEN-1:0]     rs2_data_out;
  logic                wb_we_in;
  logic [REG_BITS-1:0] wb_rd_in;
  logic [XLEN-1:0]     wb_data_in;
  logic                wb_mul_in;
  logic                issue_valid_in;
  logic [REG_BITS-1:0] issue_rd_in;
  logic                issue_mul_in;
  logic                hazard_out;
  logic [CNT_BITS-1:0] mul_cnt_out;
  logic                mul_full_out;

  modport master (
    output flush_in, rs1_in, rs2_in,
    output wb_we_in, wb_rd_in, wb_data_in, wb_mul_in,
    output issue_valid_in, issue_rd_in, issue_mul_in,
    input  rs1_data_out, rs2_data_out, hazard_out, mul_cnt_out, mul_full_out
  );

  modport slave (
    input  flush_in, rs1_in, rs2_in,
    input  wb_we_in, wb_rd_in, wb_data_in, wb_mul_in,
    input  issue_valid_in, issue_rd_in, issue_mul_in,
    output rs1_data_out, rs2_data_out, hazard_out, mul_cnt_out, mul_full_out
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a pending-bit scoreboard for multi-cycle multiplies.
// Define REGFILE_BYPASS_EN to forward writeback data and same-cycle pending clears.
module regfile_scoreboard #(
  parameter int XLEN      = 32,
  parameter int REG_BITS  = 5,
  parameter int MUL_DEPTH = 5
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 1 << REG_BITS;
  localparam int CNT_BITS = $clog2(MUL_DEPTH + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(MUL_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [REG_BITS-1:0] REG_ZERO = '0;

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [CNT_BITS-1:0] mul_cnt_q;
  logic [CNT_BITS-1:0] mul_cnt_d;

  logic [NUM_REGS-1:0] pending_vis;
  logic                mul_full;
  logic                hazard;
  logic                issue_accept;
  logic                mul_set;
  logic                wb_clear;
  logic                clear_hit;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;

  assign wb_clear     = bus.wb_we_in & bus.wb_mul_in;
  assign clear_hit    = wb_clear & pending_q[bus.wb_rd_in];
  assign mul_full     = (mul_cnt_q == CNT_MAX);
  assign issue_accept = bus.issue_valid_in & ~hazard;
  assign mul_set      = issue_accept & bus.issue_mul_in & (bus.issue_rd_in != REG_ZERO);

  // A multiply completing this cycle can release its own dependants early.
  always_comb begin
    pending_vis = pending_q;
`ifdef REGFILE_BYPASS_EN
    if (wb_clear) begin
      pending_vis[bus.wb_rd_in] = 1'b0;
    end
`endif
  end

  always_comb begin
    hazard = 1'b0;
    if (bus.issue_valid_in) begin
      if ((bus.rs1_in != REG_ZERO) && pending_vis[bus.rs1_in]) begin
        hazard = 1'b1;
      end
      if ((bus.rs2_in != REG_ZERO) && pending_vis[bus.rs2_in]) begin
        hazard = 1'b1;
      end
      if ((bus.issue_rd_in != REG_ZERO) && pending_vis[bus.issue_rd_in]) begin
        hazard = 1'b1;
      end
      if (bus.issue_mul_in && mul_full) begin
        hazard = 1'b1;
      end
    end
  end

  // Set is applied after clear so a same-edge set/clear of one register leaves it pending.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    mul_cnt_d = mul_cnt_q;
    if (bus.wb_we_in && (bus.wb_rd_in != REG_ZERO)) begin
      regs_d[bus.wb_rd_in] = bus.wb_data_in;
    end
    if (bus.flush_in) begin
      pending_d = '0;
      mul_cnt_d = '0;
    end else begin
      if (wb_clear) begin
        pending_d[bus.wb_rd_in] = 1'b0;
      end
      if (mul_set) begin
        pending_d[bus.issue_rd_in] = 1'b1;
      end
      if (mul_set && !clear_hit && (mul_cnt_q != CNT_MAX)) begin
        mul_cnt_d = mul_cnt_q + CNT_ONE;
      end else if (clear_hit && !mul_set && (mul_cnt_q != '0)) begin
        mul_cnt_d = mul_cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
      mul_cnt_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // x0 is never written, so a plain array read already returns zero for it.
  always_comb begin
    rs1_data = regs_q[bus.rs1_in];
    rs2_data = regs_q[bus.rs2_in];
`ifdef REGFILE_BYPASS_EN
    if (reset && bus.wb_we_in && (bus.wb_rd_in != REG_ZERO)) begin
      if (bus.wb_rd_in == bus.rs1_in) begin
        rs1_data = bus.wb_data_in;
      end
      if (bus.wb_rd_in == bus.rs2_in) begin
        rs2_data = bus.wb_data_in;
      end
    end
`endif
  end

  assign bus.rs1_data_out = rs1_data;
  assign bus.rs2_data_out = rs2_data;
  assign bus.hazard_out   = hazard;
  assign bus.mul_cnt_out  = mul_cnt_q;
  assign bus.mul_full_out = mul_full;
endmodule
